sr_latch_driver: RTL and testbench
==================================

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 The module SHALL have parameter SETUP_CYC, default 1, meaning the cycles S/R is stable before EN rises (legal range 1..15).
REQ-002 The module SHALL have parameter PULSE_CYC, default 4, meaning the cycles EN is high (legal range 1..15).
REQ-003 The module SHALL have parameter HOLD_CYC, default 1, meaning the cycles S/R is held after EN falls (legal range 1..15).
REQ-004 The module SHALL have parameter TIMEOUT_CYC, default 8, meaning the maximum readback wait cycles (legal range 1..255).
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-007 The module SHALL have port req_valid, input, 1 bit, meaning a write request is present.
REQ-008 The module SHALL have port req_ready, output, 1 bit, meaning the driver accepts a request.
REQ-009 The module SHALL have port req_val, input, 1 bit, giving the requested latch value (1 = set, 0 = reset).
REQ-010 The module SHALL have port done, output, 1 bit, a one-cycle completion pulse.
REQ-011 The module SHALL have port err, output, 1 bit, meaning readback mismatch; it is valid only while done is high.
REQ-012 The module SHALL have port lat_en, output, 1 bit, driving the latch enable.
REQ-013 The module SHALL have port lat_s, output, 1 bit, driving the latch set input.
REQ-014 The module SHALL have port lat_r, output, 1 bit, driving the latch reset input.
REQ-015 The module SHALL have port lat_q, input, 1 bit, the asynchronous latch Q output.
REQ-016 The module SHALL have port lat_q_, input, 1 bit, the asynchronous latch Q-bar output.

Function
REQ-017 The FSM SHALL have the states IDLE, SETUP, PULSE, HOLD, CHECK and DONE.
REQ-018 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on a clk edge where req_valid & req_ready, capturing req_val.
REQ-019 On accept, the FSM SHALL go to SETUP, driving lat_s = val and lat_r = ~val with lat_en = 0 for SETUP_CYC cycles.
REQ-020 From SETUP, the FSM SHALL go to PULSE, with lat_en = 1 for exactly PULSE_CYC cycles and lat_s/lat_r unchanged.
REQ-021 From PULSE, the FSM SHALL go to HOLD, with lat_en = 0 and lat_s/lat_r unchanged for HOLD_CYC cycles, then both cleared to 0 on leaving HOLD.
REQ-022 lat_s and lat_r SHALL never both be 1, and lat_en SHALL never be 1 in a cycle where lat_s or lat_r changes.
REQ-023 All latch outputs SHALL be registered (no combinational path from req_* to lat_*).
REQ-024 CHECK SHALL pass when the synchronized q == val and q_ == ~val; on pass or after TIMEOUT_CYC cycles, the FSM SHALL go to DONE.
REQ-025 DONE SHALL last exactly one cycle, asserting done = 1 with err = 1 if and only if CHECK timed out, and SHALL return to IDLE.
REQ-026 A new request SHALL not be accepted in the DONE cycle; the earliest accept is the following cycle.
REQ-027 Request-to-done latency SHALL be SETUP_CYC + PULSE_CYC + HOLD_CYC + k + 1 cycles, where 1 ≤ k ≤ TIMEOUT_CYC.
REQ-028 Each stage counter SHALL be 4 bits (8 bits for the timeout counter), load stage length − 1, and count down to 0 without wrap.
REQ-029 A request equal to the current latch value SHALL still execute the full sequence.

Reset
REQ-030 While rst_n = 0, the FSM SHALL be in IDLE with req_ready = 0, done = 0, err = 0, lat_en = 0, lat_s = 0, lat_r = 0, all counters = 0, and the synchronizers = 0.
REQ-031 Reset assertion mid-sequence SHALL drop lat_en, lat_s and lat_r asynchronously and abandon the request without a done pulse.
REQ-032 req_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-033 When macro SR_READBACK_EN is defined, the CHECK state and the lat_q/lat_q_ synchronizers SHALL be present as specified above.
REQ-034 When SR_READBACK_EN is undefined, HOLD SHALL go directly to DONE, err SHALL be tied to 0, lat_q/lat_q_ SHALL be unused, and latency SHALL be SETUP_CYC + PULSE_CYC + HOLD_CYC + 1.

Structure
REQ-035 A shared package SHALL hold the FSM state enum (3-bit encoding) and the counter width constants CNT_W = 4 and TO_W = 8.
REQ-036 Sub-module sync2 (a two-flop synchronizer with rst_n clear) SHALL be instantiated twice, for lat_q and lat_q_, only under SR_READBACK_EN.

Verification
REQ-037 With default parameters, req_val = 1 and a model latch, the bench SHALL see lat_s = 1 for cycles 1-6, lat_en = 1 for cycles 2-5, and done = 1 with err = 0 at cycle 9 (k = 2).
REQ-038 For req_val = 0 after a set, the bench SHALL see lat_r pulse only, lat_s = 0 throughout, and the model q = 0 at done.
REQ-039 With the model latch stuck at q = 0 and req_val = 1, the bench SHALL see done with err = 1 exactly TIMEOUT_CYC (8) cycles after entering CHECK.
REQ-040 With rst_n pulled low in PULSE cycle 2, the bench SHALL see lat_en = 0 immediately, no done pulse, and req_ready = 1 one edge after release.
REQ-041 With req_valid held high continuously, the bench SHALL see back-to-back requests accepted exactly one cycle after each done and none during the sequence.
REQ-042 With SR_READBACK_EN undefined and PULSE_CYC = 1, the bench SHALL see done at cycle 4 and err constantly 0.

Source files
------------

// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch driver: FSM state encoding,
// counter widths and counter load helpers.
package sr_latch_driver_pkg;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO_W  = 8;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_ONE  = TO_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } drv_state_t;

  // Stage counters hold "cycles remaining minus one" so a stage ends at zero.
  function automatic logic [CNT_W-1:0] stage_load(input int unsigned len);
    return CNT_W'(len - 1);
  endfunction

  function automatic logic [TO_W-1:0] timeout_load(input int unsigned len);
    return TO_W'(len - 1);
  endfunction

endpackage

// File: rtl/sr_latch_driver_sync2.sv
// Two-flop synchronizer for the asynchronous latch readback outputs.
// Both stages clear on rst_n.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Sequenced SR latch write driver: setup, enable pulse, hold, optional readback.
// Define SR_READBACK_EN to build the CHECK state and lat_q/lat_q_ synchronizers.
module sr_latch_driver
  import sr_latch_driver_pkg::*;
#(
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_val,
  output logic done,
  output logic err,
  output logic lat_en,
  output logic lat_s,
  output logic lat_r,
  input  logic lat_q,
  input  logic lat_q_
);

  drv_state_t       state;
  logic [CNT_W-1:0] stage_cnt;
  logic             ready_r;
  logic             done_r;

  assign req_ready = ready_r;
  assign done      = done_r;

`ifdef SR_READBACK_EN
  logic [TO_W-1:0] to_cnt;
  logic            val_r;
  logic            q_sync;
  logic            qn_sync;
  logic            match_r;
  logic            err_r;

  sync2 u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lat_q),
    .q     (q_sync)
  );

  sync2 u_sync_qn (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (lat_q_),
    .q     (qn_sync)
  );

  assign err = err_r;
`else
  logic unused_readback;
  assign unused_readback = lat_q ^ lat_q_;
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      stage_cnt <= '0;
      ready_r   <= 1'b0;
      done_r    <= 1'b0;
      lat_en    <= 1'b0;
      lat_s     <= 1'b0;
      lat_r     <= 1'b0;
`ifdef SR_READBACK_EN
      to_cnt    <= '0;
      val_r     <= 1'b0;
      match_r   <= 1'b0;
      err_r     <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
`ifdef SR_READBACK_EN
      err_r  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          ready_r <= 1'b1;
          if (req_valid && ready_r) begin
            ready_r   <= 1'b0;
            lat_s     <= req_val;
            lat_r     <= ~req_val;
            lat_en    <= 1'b0;
            stage_cnt <= stage_load(SETUP_CYC);
            state     <= ST_SETUP;
`ifdef SR_READBACK_EN
            val_r     <= req_val;
`endif
          end
        end

        ST_SETUP: begin
          if (stage_cnt == '0) begin
            lat_en    <= 1'b1;
            stage_cnt <= stage_load(PULSE_CYC);
            state     <= ST_PULSE;
          end else begin
            stage_cnt <= stage_cnt - CNT_ONE;
          end
        end

        ST_PULSE: begin
          if (stage_cnt == '0) begin
            lat_en    <= 1'b0;
            stage_cnt <= stage_load(HOLD_CYC);
            state     <= ST_HOLD;
          end else begin
            stage_cnt <= stage_cnt - CNT_ONE;
          end
        end

        ST_HOLD: begin
          if (stage_cnt == '0) begin
            lat_s <= 1'b0;
            lat_r <= 1'b0;
`ifdef SR_READBACK_EN
            to_cnt  <= timeout_load(TIMEOUT_CYC);
            match_r <= 1'b0;
            state   <= ST_CHECK;
`else
            done_r  <= 1'b1;
            state   <= ST_DONE;
`endif
          end else begin
            stage_cnt <= stage_cnt - CNT_ONE;
          end
        end

`ifdef SR_READBACK_EN
        // Compare is registered, so a readback that already agrees on entry
        // still spends two cycles here.
        ST_CHECK: begin
          match_r <= (q_sync == val_r) && (qn_sync == ~val_r);
          if (match_r) begin
            to_cnt <= '0;
            done_r <= 1'b1;
            state  <= ST_DONE;
          end else if (to_cnt == '0) begin
            done_r <= 1'b1;
            err_r  <= 1'b1;
            state  <= ST_DONE;
          end else begin
            to_cnt <= to_cnt - TO_ONE;
          end
        end
`endif

        ST_DONE: begin
          ready_r <= 1'b1;
          state   <= ST_IDLE;
        end

        default: begin
          ready_r <= 1'b0;
          lat_en  <= 1'b0;
          lat_s   <= 1'b0;
          lat_r   <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_no_sr_overlap: assert property (@(posedge clk) disable iff (!rst_n)
    !(lat_s && lat_r));
  a_en_inputs_stable: assert property (@(posedge clk) disable iff (!rst_n)
    lat_en |-> $stable({lat_s, lat_r}));
  a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst_n)
    req_ready |-> (state == ST_IDLE));
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver with a behavioural SR latch model.
// Build with SR_READBACK_EN to exercise readback (PULSE_CYC=4), else PULSE_CYC=1.
module tb_sr_latch_driver;

  localparam int SETUP_CYC   = 1;
  localparam int HOLD_CYC    = 1;
  localparam int TIMEOUT_CYC = 8;
`ifdef SR_READBACK_EN
  localparam int PULSE_CYC = 4;
  localparam bit READBACK  = 1'b1;
`else
  localparam int PULSE_CYC = 1;
  localparam bit READBACK  = 1'b0;
`endif
  localparam int DRIVE_END = SETUP_CYC + PULSE_CYC + HOLD_CYC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_val = 1'b0;
  logic req_ready, done, err, lat_en, lat_s, lat_r, lat_q, lat_q_;

  always #5 clk = ~clk;

  sr_latch_driver #(
    .SETUP_CYC   (SETUP_CYC),
    .PULSE_CYC   (PULSE_CYC),
    .HOLD_CYC    (HOLD_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_val   (req_val),
    .done      (done),
    .err       (err),
    .lat_en    (lat_en),
    .lat_s     (lat_s),
    .lat_r     (lat_r),
    .lat_q     (lat_q),
    .lat_q_    (lat_q_)
  );

  // Transparent-high SR latch; 'stuck' models a latch whose Q cannot rise.
  logic q_m;
  bit   stuck = 1'b1;
  always_latch begin
    if (stuck)                q_m <= 1'b0;
    else if (lat_en && lat_s) q_m <= 1'b1;
    else if (lat_en && lat_r) q_m <= 1'b0;
  end
  assign lat_q  = q_m;
  assign lat_q_ = ~q_m;

  typedef struct {
    int a;
    bit val;
    bit stuck;
    bit err;
    int lat;
  } txn_t;

  txn_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   in_reset = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Monitor: per-cycle expected outputs derived from the outstanding request.
  txn_t cur;
  int   rel;
  bit   e_en, e_s, e_r, e_rdy, e_done, e_err;
  always @(negedge clk) begin
    if (!in_reset) begin
      e_en = 1'b0; e_s = 1'b0; e_r = 1'b0; e_rdy = 1'b1; e_done = 1'b0; e_err = 1'b0;
      if (exp_q.size() != 0) begin
        cur    = exp_q[0];
        rel    = cyc - cur.a;
        e_rdy  = 1'b0;
        e_s    = cur.val  && rel >= 1 && rel <= DRIVE_END;
        e_r    = !cur.val && rel >= 1 && rel <= DRIVE_END;
        e_en   = rel > SETUP_CYC && rel <= SETUP_CYC + PULSE_CYC;
        e_done = (rel == cur.lat);
        e_err  = e_done && cur.err;
      end
      chk("outputs{en,s,r,ready,done}", {lat_en, lat_s, lat_r, req_ready, done},
          {e_en, e_s, e_r, e_rdy, e_done});
      if (done || !READBACK) chk("err", {4'b0, err}, {4'b0, e_err});
      if (e_done) begin
        chk("latch_q_at_done", {4'b0, lat_q}, {4'b0, cur.val && !cur.stuck});
        void'(exp_q.pop_front());
      end
    end
  end

  // Issue one request starting at a negedge; returns at the negedge after accept.
  task automatic issue(input bit val, input bit keep_valid);
    bit   rdy;
    int   n;
    txn_t t;
    req_valid = 1'b1;
    req_val   = val;
    rdy = 1'b0;
    n   = 0;
    while (!rdy && n < 200) begin
      rdy = req_ready;
      @(posedge clk);
      n++;
      if (!rdy) @(negedge clk);
    end
    if (!rdy) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout cycle %0d: got no accept expected accept", cyc);
    end else begin
      t.a     = cyc;
      t.val   = val;
      t.stuck = stuck;
      t.err   = READBACK && stuck && val;
      // Readback: an agreeing latch is seen after 2 CHECK cycles, else full timeout.
      t.lat   = DRIVE_END + 1 + (READBACK ? (t.err ? TIMEOUT_CYC : 2) : 0);
      exp_q.push_back(t);
    end
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    req_val = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL done_timeout cycle %0d: got no done expected done", cyc);
      exp_q.delete();
    end
  endtask

  task automatic reset_mid_pulse();
    int target;
    target = SETUP_CYC + ((PULSE_CYC >= 2) ? 2 : 1);
    issue(1'b1, 1'b0);
    repeat (target - 1) @(negedge clk);
    chk("en_before_reset", {4'b0, lat_en}, 5'b00001);
    #1;
    in_reset = 1'b1;
    rst_n    = 1'b0;
    #1;
    chk("async_reset_drop{en,s,r}", {2'b0, lat_en, lat_s, lat_r}, 5'b0);
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("reset_hold{ready,done,err}", {2'b0, req_ready, done, err}, 5'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_release", {4'b0, req_ready}, 5'b00001);
    in_reset = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_state", {req_ready, done, err, lat_en, lat_s | lat_r}, 5'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", {4'b0, req_ready}, 5'b00001);
    stuck    = 1'b0;
    in_reset = 1'b0;

    // Set, then reset, then repeat the current value.
    issue(1'b1, 1'b0); wait_drain();
    issue(1'b0, 1'b0); wait_drain();
    issue(1'b0, 1'b0); wait_drain();

    // Latch stuck low: set request should time out (readback build), reset passes.
    stuck = 1'b1;
    issue(1'b1, 1'b0); wait_drain();
    issue(1'b0, 1'b0); wait_drain();
    @(negedge clk);
    stuck = 1'b0;

    reset_mid_pulse();

    // Back-to-back with req_valid held high.
    for (int i = 0; i < 12; i++) issue(1'($urandom), 1'b1);
    req_valid = 1'b0;
    wait_drain();

    // Randomized requests, latch faults and idle gaps.
    for (int i = 0; i < 30; i++) begin
      stuck = ($urandom_range(0, 3) == 0);
      issue(1'($urandom), 1'b0);
      wait_drain();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    stuck = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycle %0d: got hang expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
